svm_cfg_loader: RTL

// - Configuration sequencer for the HOG+SVM pipeline. Takes a host stream of SVM coefficients (valid/ready).
// - Packs N_COEF coefficients per RAM word and writes N_WORD words into the SVM coefficient RAM, then loads the bias.
// - Gates the pixel-fetch ready path so detection runs only once a complete model is loaded.

---
 rtl/svm_cfg_loader.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/svm_cfg_loader.sv
// svm_cfg_loader: packs host SVM coefficients into RAM words, writes the model, then loads the bias.
// Build macro SVM_READBACK_EN adds a checksum readback pass (ram_rdata in, cfg_err out) before DONE.
module svm_cfg_loader #(
   parameter int FEA_W  = 16,
   parameter int N_COEF = 105,
   parameter int N_WORD = 36,
   parameter int ADDR_W = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [FEA_W-1:0]        s_data,
   output logic [ADDR_W-1:0]       addr_a,
   output logic                    write_en,
   output logic [FEA_W*N_COEF-1:0] o_wdata,
   output logic [FEA_W-1:0]        bias,
   output logic                    b_load,
   input  logic                    fifo_rdy_in,
   output logic                    fifo_rdy_out,
   output logic                    busy,
`ifdef SVM_READBACK_EN
   input  logic [FEA_W*N_COEF-1:0] ram_rdata,
   output logic                    cfg_err,
`endif
   output logic                    cfg_done
);

   localparam int RAM_DW = FEA_W * N_COEF;
   localparam int CW     = $clog2(N_COEF + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WRITE, S_BIAS, S_BSTB, S_VERIFY, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic                s_ready_q, s_ready_d;
   logic                write_en_q, write_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [RAM_DW-1:0]   wdata_q, wdata_d;
   logic [FEA_W-1:0]    bias_q, bias_d;
   logic                b_load_q, b_load_d;
   logic                busy_q, busy_d;
   logic                cfg_done_q, cfg_done_d;
   logic [CW-1:0]       coef_cnt_q, coef_cnt_d;
   logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
   logic                fire;

`ifdef SVM_READBACK_EN
   logic [FEA_W-1:0]    csum_q, csum_d;
   logic [FEA_W-1:0]    acc_q, acc_d;
   logic                iss_q, iss_d;
   logic                pend_q, pend_d;
   logic                cfg_err_q, cfg_err_d;

   function automatic logic [FEA_W-1:0] fold(input logic [RAM_DW-1:0] w);
      logic [FEA_W-1:0] f;
      f = '0;
      for (int i = 0; i < N_COEF; i++) f = f ^ w[i*FEA_W +: FEA_W];
      return f;
   endfunction
`endif

   assign fire = s_valid & s_ready_q;

   always_comb begin
      // NOTE: every _d gets a default here so no path leaves one unassigned (no latches).
      state_d    = state_q;
      s_ready_d  = s_ready_q;
      write_en_d = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bias_d     = bias_q;
      b_load_d   = 1'b0;
      busy_d     = busy_q;
      cfg_done_d = cfg_done_q;
      coef_cnt_d = coef_cnt_q;
      word_cnt_d = word_cnt_q;
`ifdef SVM_READBACK_EN
      csum_d     = csum_q;
      acc_d      = acc_q;
      iss_d      = iss_q;
      pend_d     = pend_q;
      cfg_err_d  = cfg_err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LOAD;
               s_ready_d  = 1'b1;
               busy_d     = 1'b1;
               cfg_done_d = 1'b0;
               coef_cnt_d = '0;
               word_cnt_d = '0;
`ifdef SVM_READBACK_EN
               csum_d     = '0;
               cfg_err_d  = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (fire) begin
               // First coefficient of a word shifts down to bits [FEA_W-1:0] by the last one.
               wdata_d    = {s_data, wdata_q[RAM_DW-1:FEA_W]};
               coef_cnt_d = coef_cnt_q + 1'b1;
`ifdef SVM_READBACK_EN
               csum_d     = csum_q ^ s_data;
`endif
               if (coef_cnt_q == CW'(N_COEF - 1)) begin
                  state_d    = S_WRITE;
                  s_ready_d  = 1'b0;
                  write_en_d = 1'b1;
                  addr_d     = word_cnt_q;
               end
            end
         end
         S_WRITE: begin
            coef_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            s_ready_d  = 1'b1;
            state_d    = (word_cnt_q == ADDR_W'(N_WORD - 1)) ? S_BIAS : S_LOAD;
         end
         S_BIAS: begin
            if (fire) begin
               bias_d    = s_data;
               b_load_d  = 1'b1;
               s_ready_d = 1'b0;
               state_d   = S_BSTB;
            end
         end
         S_BSTB: begin
`ifdef SVM_READBACK_EN
            state_d = S_VERIFY;
            addr_d  = '0;
            iss_d   = 1'b1;
            pend_d  = 1'b0;
            acc_d   = '0;
`else
            state_d    = S_DONE;
            busy_d     = 1'b0;
            cfg_done_d = 1'b1;
`endif
         end
`ifdef SVM_READBACK_EN
         S_VERIFY: begin
            // One address issued per cycle; its read data arrives, and is folded, one cycle later.
            pend_d = iss_q;
            if (iss_q) begin
               if (addr_q == ADDR_W'(N_WORD - 1)) iss_d = 1'b0;
               else                                addr_d = addr_q + 1'b1;
            end
            if (pend_q) begin
               acc_d = acc_q ^ fold(ram_rdata);
               if (!iss_q) begin
                  busy_d = 1'b0;
                  if (acc_d == csum_q) begin
                     state_d    = S_DONE;
                     cfg_done_d = 1'b1;
                  end else begin
                     state_d   = S_ERR;
                     cfg_err_d = 1'b1;
                  end
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         s_ready_q  <= 1'b0;
         write_en_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         bias_q     <= '0;
         b_load_q   <= 1'b0;
         busy_q     <= 1'b0;
         cfg_done_q <= 1'b0;
         coef_cnt_q <= '0;
         word_cnt_q <= '0;
`ifdef SVM_READBACK_EN
         csum_q     <= '0;
         acc_q      <= '0;
         iss_q      <= 1'b0;
         pend_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
         state_q    <= state_d;
         s_ready_q  <= s_ready_d;
         write_en_q <= write_en_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         bias_q     <= bias_d;
         b_load_q   <= b_load_d;
         busy_q     <= busy_d;
         cfg_done_q <= cfg_done_d;
         coef_cnt_q <= coef_cnt_d;
         word_cnt_q <= word_cnt_d;
`ifdef SVM_READBACK_EN
         csum_q     <= csum_d;
         acc_q      <= acc_d;
         iss_q      <= iss_d;
         pend_q     <= pend_d;
         cfg_err_q  <= cfg_err_d;
`endif
      end
   end

   assign s_ready      = s_ready_q;
   assign write_en     = write_en_q;
   assign addr_a       = addr_q;
   assign o_wdata      = wdata_q;
   assign bias         = bias_q;
   assign b_load       = b_load_q;
   assign busy         = busy_q;
   assign cfg_done     = cfg_done_q;
   assign fifo_rdy_out = fifo_rdy_in & cfg_done_q;
`ifdef SVM_READBACK_EN
   assign cfg_err      = cfg_err_q;
`endif

endmodule
